// File: rtl/gate_request_queue.sv
// ---------------------------------------------------------------------------
// gate_request_queue
//
// Front-end stage for the area access controller. Swipe requests from two
// turnstile gates (A, B) are buffered in one shared in-order FIFO and issued
// to the controller at most one per cycle. While a List command is occupying
// the controller, issue is held off for LIST_CYCLES-1 further cycles.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   a_valid/a_mode/a_userID  gate A request, a_ready = accepted this edge
//   b_valid/b_mode/b_userID  gate B request, b_ready = accepted this edge
//   out_valid                new command on out_mode/out_userID this cycle
//   out_mode, out_userID     command to the controller
//   busy                     List stall in progress
//   level                    entries currently held in the FIFO
//
// Mode encoding: 01 Entrance, 00 Exit, 10 Search, 11 List.
// userID format: [5:4] AreaID, [3:0] UserID.
// ---------------------------------------------------------------------------
module gate_request_queue #(
    parameter int DEPTH       = 8,
    parameter int LIST_CYCLES = 4,
    parameter int LW          = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    input  logic [1:0]    a_mode,
    input  logic [5:0]    a_userID,
    output logic          a_ready,
    input  logic          b_valid,
    input  logic [1:0]    b_mode,
    input  logic [5:0]    b_userID,
    output logic          b_ready,
    output logic          out_valid,
    output logic [1:0]    out_mode,
    output logic [5:0]    out_userID,
    output logic          busy,
    output logic [LW-1:0] level
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (LIST_CYCLES > 1) ? $clog2(LIST_CYCLES) : 1;

    typedef enum logic [1:0] {
        MODE_EXIT     = 2'b00,
        MODE_ENTRANCE = 2'b01,
        MODE_SEARCH   = 2'b10,
        MODE_LIST     = 2'b11
    } mode_e;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_e;

    typedef struct packed {
        logic [1:0] mode;
        logic [5:0] user_id;
    } entry_t;

    entry_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic [CW-1:0] r_stall;
    prio_e         r_prio;
    logic          r_out_valid;
    logic [1:0]    r_out_mode;
    logic [5:0]    r_out_user_id;

    logic [LW-1:0] w_free;
    logic          w_free_one;
    logic          w_a_ready;
    logic          w_b_ready;
    logic          w_push_a;
    logic          w_push_b;
    logic          w_pop;
    logic [PW-1:0] w_wr_ptr_b;
    entry_t        w_head;

    // Readiness comes from registered occupancy only: a pop in the same
    // edge does not free a slot for the gates until the next cycle.
    assign w_free     = LW'(DEPTH) - r_level;
    assign w_free_one = (w_free == LW'(1));
    assign w_a_ready  = (w_free >= LW'(2)) || (w_free_one && (r_prio == PRIO_A));
    assign w_b_ready  = (w_free >= LW'(2)) || (w_free_one && (r_prio == PRIO_B));

    assign w_push_a   = a_valid && w_a_ready;
    assign w_push_b   = b_valid && w_b_ready;
    assign w_pop      = (r_level != '0) && (r_stall == '0);

    // B lands in the slot after A when both gates transfer on the same edge.
    assign w_wr_ptr_b = r_wr_ptr + PW'(w_push_a);
    assign w_head     = r_mem[r_rd_ptr];

    // NOTE: storage array has no reset; occupancy is tracked by the pointers
    // and level, so stale contents are never observed after a reset.
    always_ff @(posedge clk) begin
        if (w_push_a) begin
            r_mem[r_wr_ptr] <= '{mode: a_mode, user_id: a_userID};
        end
        if (w_push_b) begin
            r_mem[w_wr_ptr_b] <= '{mode: b_mode, user_id: b_userID};
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_stall       <= '0;
            r_prio        <= PRIO_A;
            r_out_valid   <= 1'b0;
            r_out_mode    <= MODE_SEARCH;
            r_out_user_id <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_push_a) + PW'(w_push_b);
            r_level  <= r_level + LW'(w_push_a) + LW'(w_push_b) - LW'(w_pop);

            // Only the priority holder can be ready at free==1, so any
            // transfer there is the holder's and hands priority over.
            if (w_free_one && (w_push_a || w_push_b)) begin
                r_prio <= (r_prio == PRIO_A) ? PRIO_B : PRIO_A;
            end

            if (w_pop) begin
                r_rd_ptr      <= r_rd_ptr + PW'(1);
                r_out_valid   <= 1'b1;
                r_out_mode    <= w_head.mode;
                r_out_user_id <= w_head.user_id;
                // A List holds the controller for LIST_CYCLES cycles in
                // total, this issue cycle included.
                if (w_head.mode == MODE_LIST) begin
                    r_stall <= CW'(LIST_CYCLES - 1);
                end
            end else begin
                // Idle cycles present the non-mutating Search mode.
                r_out_valid <= 1'b0;
                r_out_mode  <= MODE_SEARCH;
                if (r_stall != '0) begin
                    r_stall <= r_stall - CW'(1);
                end
            end
        end
    end

    assign a_ready    = w_a_ready;
    assign b_ready    = w_b_ready;
    assign out_valid  = r_out_valid;
    assign out_mode   = r_out_mode;
    assign out_userID = r_out_user_id;
    assign busy       = (r_stall != '0);
    assign level      = r_level;

endmodule

// File: tb/tb_gate_request_queue.sv
// ---------------------------------------------------------------------------
// tb_gate_request_queue
//
// Directed stimulus for gate_request_queue. A queue-based reference model
// tracks acceptance order, the List hold-off and priority; every cycle its
// outputs are compared with the DUT, and hand-computed literal checks pin
// the model at the key points of each scenario.
// ---------------------------------------------------------------------------
module tb_gate_request_queue;

    localparam int DEPTH       = 8;
    localparam int LIST_CYCLES = 4;
    localparam int LW          = $clog2(DEPTH + 1);

    logic          clk;
    logic          rst;
    logic          a_valid;
    logic [1:0]    a_mode;
    logic [5:0]    a_userID;
    logic          a_ready;
    logic          b_valid;
    logic [1:0]    b_mode;
    logic [5:0]    b_userID;
    logic          b_ready;
    logic          out_valid;
    logic [1:0]    out_mode;
    logic [5:0]    out_userID;
    logic          busy;
    logic [LW-1:0] level;

    int checks = 0;
    int errors = 0;

    gate_request_queue #(
        .DEPTH       (DEPTH),
        .LIST_CYCLES (LIST_CYCLES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_mode     (a_mode),
        .a_userID   (a_userID),
        .a_ready    (a_ready),
        .b_valid    (b_valid),
        .b_mode     (b_mode),
        .b_userID   (b_userID),
        .b_ready    (b_ready),
        .out_valid  (out_valid),
        .out_mode   (out_mode),
        .out_userID (out_userID),
        .busy       (busy),
        .level      (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] m_q[$];       // {mode, userID} in acceptance order
    int         m_stall = 0;  // remaining hold-off cycles after a List
    bit         m_prio  = 0;  // 0 = gate A holds priority, 1 = gate B
    bit         m_ov    = 0;
    logic [1:0] m_mode  = 2'b10;
    logic [5:0] m_uid   = '0;
    bit         m_live  = 0;

    int         md_free;
    bit         md_pa;
    bit         md_pb;
    logic [7:0] md_e;

    function automatic bit m_ready(input bit gate);
        int free;
        free = DEPTH - m_q.size();
        return (free >= 2) || (free == 1 && m_prio == gate);
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_q.delete();
            m_stall = 0;
            m_prio  = 0;
            m_ov    = 0;
            m_mode  = 2'b10;
            m_uid   = '0;
            m_live  = 1;
        end else if (m_live) begin
            md_free = DEPTH - m_q.size();
            md_pa   = a_valid && m_ready(0);
            md_pb   = b_valid && m_ready(1);
            if (m_q.size() > 0 && m_stall == 0) begin
                md_e   = m_q.pop_front();
                m_ov   = 1;
                m_mode = md_e[7:6];
                m_uid  = md_e[5:0];
                if (md_e[7:6] == 2'b11) m_stall = LIST_CYCLES - 1;
            end else begin
                m_ov   = 0;
                m_mode = 2'b10;
                if (m_stall > 0) m_stall--;
            end
            if (md_pa) m_q.push_back({a_mode, a_userID});
            if (md_pb) m_q.push_back({b_mode, b_userID});
            if (md_free == 1 && ((m_prio == 0 && md_pa) || (m_prio == 1 && md_pb)))
                m_prio = ~m_prio;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        wait (m_live);
        forever begin
            @(negedge clk);
            check("model out_valid",  out_valid,  m_ov);
            check("model out_mode",   out_mode,   m_mode);
            check("model out_userID", out_userID, m_uid);
            check("model busy",       busy,       m_stall != 0);
            check("model level",      level,      m_q.size());
            check("model a_ready",    a_ready,    m_ready(0));
            check("model b_ready",    b_ready,    m_ready(1));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit av, input logic [1:0] am, input logic [5:0] au,
                         input bit bv, input logic [1:0] bm, input logic [5:0] bu);
        a_valid  = av;
        a_mode   = am;
        a_userID = au;
        b_valid  = bv;
        b_mode   = bm;
        b_userID = bu;
    endtask

    task automatic idle();
        drive(0, 2'b00, 6'h00, 0, 2'b00, 6'h00);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " level"},      level,      0);
        check({tag, " out_valid"},  out_valid,  0);
        check({tag, " out_mode"},   out_mode,   2'b10);
        check({tag, " out_userID"}, out_userID, 0);
        check({tag, " busy"},       busy,       0);
        check({tag, " a_ready"},    a_ready,    1);
        check({tag, " b_ready"},    b_ready,    1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        rst = 1'b1;
        idle();
        repeat (2) step();
        rst = 1'b0;
        check_reset_state("reset");

        // 1: single Entrance, one-cycle latency
        drive(1, 2'b01, 6'h01, 0, 2'b00, 6'h00);
        step();
        idle();
        check("t1 level after push", level, 1);
        check("t1 out_valid N", out_valid, 0);
        step();
        check("t1 out_valid N+1", out_valid, 1);
        check("t1 out_mode N+1", out_mode, 2'b01);
        check("t1 out_userID N+1", out_userID, 6'h01);
        step();
        check("t1 out_valid N+2", out_valid, 0);
        check("t1 out_mode N+2", out_mode, 2'b10);
        check("t1 level N+2", level, 0);

        // 2: both gates same edge, A first
        drive(1, 2'b01, 6'h03, 1, 2'b01, 6'h32);
        step();
        idle();
        check("t2 level 2", level, 2);
        step();
        check("t2 first issue", out_userID, 6'h03);
        check("t2 level 1", level, 1);
        step();
        check("t2 second valid", out_valid, 1);
        check("t2 second issue", out_userID, 6'h32);
        check("t2 level 0", level, 0);

        // 3: List then Entrance, three busy cycles
        drive(1, 2'b11, 6'h20, 0, 2'b00, 6'h00);
        step();
        drive(1, 2'b01, 6'h04, 0, 2'b00, 6'h00);
        step();
        idle();
        check("t3 list valid", out_valid, 1);
        check("t3 list mode", out_mode, 2'b11);
        check("t3 list userID", out_userID, 6'h20);
        check("t3 busy c1", busy, 1);
        step();
        check("t3 busy c2", busy, 1);
        check("t3 held c2", out_valid, 0);
        step();
        check("t3 busy c3", busy, 1);
        check("t3 held c3", out_valid, 0);
        step();
        check("t3 busy clear", busy, 0);
        check("t3 held c4", out_valid, 0);
        step();
        check("t3 entrance valid", out_valid, 1);
        check("t3 entrance mode", out_mode, 2'b01);
        check("t3 entrance userID", out_userID, 6'h04);

        // 4: fill behind a List stall with IDs 2..9
        drive(1, 2'b11, 6'h01, 0, 2'b00, 6'h00);
        step();
        for (int i = 0; i < 4; i++) begin
            drive(1, 2'b01, 6'(2 + 2 * i), 1, 2'b01, 6'(3 + 2 * i));
            step();
        end
        idle();
        check("t4 level full", level, 8);
        check("t4 a_ready full", a_ready, 0);
        check("t4 b_ready full", b_ready, 0);
        for (int k = 0; k < 8; k++) begin
            step();
            check("t4 drain valid", out_valid, 1);
            check("t4 drain order", out_userID, 6'(2 + k));
        end
        step();
        check("t4 empty", level, 0);

        // 5: priority at free==1
        drive(1, 2'b11, 6'h3F, 0, 2'b00, 6'h00);
        step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b00, 6'(8'h10 + i), 1, 2'b00, 6'(8'h20 + i));
            step();
        end
        drive(1, 2'b00, 6'h13, 0, 2'b00, 6'h00);
        step();
        check("t5 level 7", level, 7);
        check("t5 a_ready prio A", a_ready, 1);
        check("t5 b_ready prio A", b_ready, 0);
        drive(1, 2'b00, 6'h14, 1, 2'b00, 6'h23);
        step();
        check("t5 level after A", level, 7);
        check("t5 a_ready prio B", a_ready, 0);
        check("t5 b_ready prio B", b_ready, 1);
        check("t5 head issued", out_userID, 6'h10);
        drive(1, 2'b00, 6'h15, 1, 2'b00, 6'h23);
        step();
        idle();
        check("t5 level after B", level, 7);
        check("t5 a_ready back to A", a_ready, 1);
        check("t5 b_ready back to A", b_ready, 0);
        check("t5 second issued", out_userID, 6'h20);
        repeat (9) step();
        check("t5 drained", level, 0);

        // 6: reset mid-stall with entries queued
        drive(1, 2'b11, 6'h2A, 0, 2'b00, 6'h00);
        step();
        drive(1, 2'b01, 6'h01, 1, 2'b01, 6'h02);
        step();
        drive(1, 2'b01, 6'h03, 1, 2'b01, 6'h04);
        step();
        drive(1, 2'b01, 6'h05, 0, 2'b00, 6'h00);
        step();
        idle();
        check("t6 level before rst", level, 5);
        check("t6 busy before rst", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_state("t6 after rst");
        for (int k = 0; k < 10; k++) begin
            step();
            check("t6 no stale issue", out_valid, 0);
        end
        check("t6 level stays 0", level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
